mdu_iterative: RTL and testbench
================================

# mdu_iterative

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS R2000 pipeline. It sits beside the ALU in the EX stage and accepts MULT, MULTU, DIV and DIVU from the ID/EX register. It computes the result over multiple cycles and raises a stall request toward the hazard detection unit. The stall holds PC, IF/ID and ID/EX whenever a conflicting instruction reaches EX while the unit is busy.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width; an even number of 4 or more.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter.

Ports (clock and reset are listed first):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin the operation selected by op; sampled only in IDLE.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- rs_data  in  WIDTH  multiplicand or dividend.
- rt_data  in  WIDTH  multiplier or divisor.
- hilo_rd  in  1  MFHI or MFLO is in EX this cycle.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  data for MTHI/MTLO.
- flush  in  1  abort the operation in progress.
- busy  out  1  high when state is not IDLE.
- stall  out  1  combinational: busy & (start | hilo_rd | mthi | mtlo).
- done  out  1  one-cycle pulse after HI/LO are updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE → RUN on start & !flush.
  - With MDU_FAST_MUL_EN defined, a multiply in IDLE goes directly to FIX instead of RUN.
  - RUN → FIX when the counter reaches WIDTH.
  - FIX → IDLE.
  - flush from RUN or FIX → IDLE.
- Signed ops:
  - Magnitudes of both operands are latched at start.
  - The product is negated in FIX when the operand signs differ.
  - The quotient is negative when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Multiply: shift-add, one bit per RUN cycle. Full 2·WIDTH product goes to {hi, lo}.
- Divide: restoring division, one quotient bit per RUN cycle. Quotient goes to lo, remainder to hi.
- Divide by zero, decided at start: lo = all ones, hi = rs_data unmodified. RUN cycles are still spent so latency stays constant.
- Signed overflow (most-negative value / −1): lo = most-negative value, hi = 0.
- MTHI/MTLO:
  - Write at the clock edge only when busy is low.
  - While busy is high the write is ignored and stall is asserted.
- start while busy: ignored; stall is held high so the pipeline re-presents the instruction.
- flush:
  - HI/LO are unchanged and done is not asserted.
  - If flush is asserted together with start in IDLE, flush wins.
- An operation's FIX write overrides a same-cycle MTHI/MTLO. This case cannot occur because busy is high during FIX.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation clears everything immediately; done is not pulsed.
- Iterative operation (start sampled at edge E0):
  - busy is high in the cycles following edges E0 through E0+WIDTH.
  - HI/LO are updated at edge E0+WIDTH+1.
  - done is high for the single cycle after E0+WIDTH+1.
  - Latency is WIDTH+1 cycles; for WIDTH=32, that is 33.
- Fast multiply: HI/LO are updated at E0+1 and done follows that edge. Latency is 1.
- hi and lo are registered outputs. MFHI/MFLO read them directly once stall drops.
- Back-to-back: a new start is accepted in the first cycle after the operation returns to IDLE.

## Configuration
- MDU_FAST_MUL_EN:
  - Defined: MULT/MULTU use a single registered WIDTH×WIDTH multiply with 1-cycle latency. Divide stays iterative.
  - Undefined: both multiply and divide are iterative with latency WIDTH+1, and no hardware multiplier is inferred.

## Structure
- Package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - the state enum (IDLE, RUN, FIX);
  - the operation-class helper function is_signed(op).
- Sub-module mdu_div_step: combinational restoring-divide iteration, with the partial remainder and divisor as inputs, and the next remainder and quotient bit as outputs. It is instantiated once and reused every RUN cycle.
- The top level holds the FSM, counter, operand and accumulator registers, sign fix-up, and the HI/LO registers.

## Test plan
All values assume WIDTH=32 with MDU_FAST_MUL_EN undefined unless stated.
- MULT, rs=0xFFFFFFFD (−3), rt=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once; busy low in the next cycle.
- MULTU, rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Repeat with MDU_FAST_MUL_EN defined: same result with latency 1.
- DIV, rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU, rs=100, rt=0 → lo=0xFFFFFFFF, hi=0x64.
- Flush and stall behaviour:
  - Setup: MTHI 0x1234, then start MULTU.
  - hilo_rd=1 at cycle 5 → stall=1.
  - flush at cycle 10 → hi=0x1234, no done, busy=0 at cycle 11.
- Reset mid-operation: rst low at cycle 5 → hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Brief    : Op encodings, FSM state type and helpers for the iterative MDU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_mul(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iterative_if.sv
// ============================================================================
// Module   : mdu_iterative_if
// Brief    : EX-stage request/response bundle between pipeline and MDU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hilo_rd;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hilo_rd, mthi, mtlo, wdata, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hilo_rd, mthi, mtlo, wdata, flush,
        output busy, stall, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_div_step.sv
// ============================================================================
// Module   : mdu_div_step
// Brief    : One combinational restoring-division iteration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH:0]   i_rem,
    input  wire logic [WIDTH-1:0] i_div,
    output logic      [WIDTH-1:0] o_rem,
    output logic                  o_qbit
);

    logic [WIDTH:0] w_diff;

    // Partial remainder stays below the divisor, so the trial difference
    // fits in WIDTH bits and its top bit is a clean borrow flag.
    assign w_diff = i_rem - {1'b0, i_div};
    assign o_qbit = ~w_diff[WIDTH];
    assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : i_rem[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mdu_iterative.sv
// ============================================================================
// Module   : mdu_iterative
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and stall request.
//            Optional MDU_FAST_MUL_EN: single-cycle registered multiply.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mdu_iterative_if.slave bus
);

    mdu_state_t         r_state;
    mdu_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_mul;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH:0]   r_acc;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [WIDTH-1:0]   r_dz_rs;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_busy;
    logic               w_start_ok;
    logic               w_fast_mul;
    logic               w_last;
    logic               w_sgn;
    logic               w_op_mul;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_upper;
    logic [2*WIDTH:0]   w_mul_next;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_qbit;
    logic [2*WIDTH:0]   w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_op_mul   = is_mul(bus.op);
    assign w_sgn      = is_signed(bus.op);
    assign w_start_ok = (r_state == IDLE) & bus.start & ~bus.flush;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_mag_a    = (w_sgn & bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign w_mag_b    = (w_sgn & bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
    assign w_fast_mul  = w_op_mul;
`else
    assign w_fast_mul  = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = w_fast_mul ? FIX : RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy    = (r_state != IDLE);
        bus.stall = w_busy & (bus.start | bus.hilo_rd | bus.mthi | bus.mtlo);
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // Shift-add: upper half (with carry bit) accumulates, multiplier drains out the bottom.
    assign w_mul_upper = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    assign w_mul_next  = {1'b0, w_mul_upper, r_acc[WIDTH-1:1]};

    // Divide layout: r_acc[2W-1:W] partial remainder, r_acc[W-1:0] dividend/quotient.
    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem  (r_acc[2*WIDTH-1:WIDTH-1]),
        .i_div  (r_m),
        .o_rem  (w_div_rem),
        .o_qbit (w_div_qbit)
    );

    assign w_div_next = {1'b0, w_div_rem, r_acc[WIDTH-2:0], w_div_qbit};

    assign w_prod_fix = r_neg_res ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];

    // Sign fix-up; most-negative / -1 falls out naturally as quotient 0x8..0, remainder 0.
    always_comb begin
        w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        if (r_is_mul) begin
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_fix[WIDTH-1:0];
        end else if (r_dz) begin
            w_fix_hi = r_dz_rs;
            w_fix_lo = {WIDTH{1'b1}};
        end
    end

    // ---------------- datapath and HI/LO ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_m       <= '0;
            r_acc     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_dz_rs   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_cnt     <= '0;
                        r_is_mul  <= w_op_mul;
                        r_neg_res <= w_sgn & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                        r_neg_rem <= w_sgn & bus.rs_data[WIDTH-1];
                        r_dz      <= ~w_op_mul & (bus.rt_data == '0);
                        r_dz_rs   <= bus.rs_data;
                        r_m       <= w_op_mul ? w_mag_a : w_mag_b;
                        r_acc     <= {{(WIDTH+1){1'b0}}, (w_op_mul ? w_mag_b : w_mag_a)};
`ifdef MDU_FAST_MUL_EN
                        if (w_op_mul) begin
                            r_acc <= {1'b0, w_fast_prod};
                        end
`endif
                    end
                    if (bus.mthi) begin
                        r_hi <= bus.wdata;
                    end
                    if (bus.mtlo) begin
                        r_lo <= bus.wdata;
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_acc <= r_is_mul ? w_mul_next : w_div_next;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// ============================================================================
// Module   : tb_mdu_iterative
// Brief    : Directed self-checking bench for mdu_iterative (WIDTH=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int         MUL_LAT  = 1;
    localparam logic [1:0] FLUSH_OP = MDU_DIVU;
`else
    localparam int         MUL_LAT  = W + 1;
    localparam logic [1:0] FLUSH_OP = MDU_MULTU;
`endif
    localparam int DIV_LAT = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mdu_iterative_if #(.WIDTH(W)) bus ();

    mdu_iterative #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el,
                         input string tag);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, ".busy_hi"}, 64'(bus.busy), 64'd1);
        chk({tag, ".done_lo"}, 64'(bus.done), 64'd0);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, ".lo"}, 64'(bus.lo), 64'(el));
        chk({tag, ".busy_lo"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int seen;
        bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
        bus.hilo_rd = 0; bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0; bus.flush = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.hi", 64'(bus.hi), 64'd0);
        chk("rst.lo", 64'(bus.lo), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back operations with hand-computed results
        do_op(MDU_MULT,  32'hFFFFFFFD, 32'd7,        MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7");
        do_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        do_op(MDU_MULT,  32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h00000000, "mult_minsq");
        do_op(MDU_DIV,   32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
        do_op(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h00000000, 32'h80000000, "div_ovf");
        do_op(MDU_DIVU,  32'd100,      32'd0,        DIV_LAT, 32'h00000064, 32'hFFFFFFFF, "divu_by0");
        do_op(MDU_DIV,   32'hFFFFFF9C, 32'd0,        DIV_LAT, 32'hFFFFFF9C, 32'hFFFFFFFF, "div_neg_by0");
        do_op(MDU_DIVU,  32'd100,      32'd7,        DIV_LAT, 32'h00000002, 32'h0000000E, "divu_100by7");

        @(negedge clk) bus.hilo_rd = 1'b1;
        #1 chk("idle.stall", 64'(bus.stall), 64'd0);
        bus.hilo_rd = 1'b0;

        // flush beats start in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = MDU_MULTU;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start.busy", 64'(bus.busy), 64'd0);

        @(negedge clk) begin bus.mthi = 1'b1; bus.wdata = 32'h1234; end
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        chk("mthi.hi", 64'(bus.hi), 64'h1234);
        chk("mthi.lo_kept", 64'(bus.lo), 64'hE);

        // Stall while busy, ignored MTLO, then flush
        @(negedge clk);
        bus.start = 1'b1; bus.op = FLUSH_OP; bus.rs_data = 32'd3; bus.rt_data = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.hilo_rd = 1'b1;
        #1 chk("busy.stall_rd", 64'(bus.stall), 64'd1);
        bus.hilo_rd = 1'b0;
        #1 chk("busy.stall_none", 64'(bus.stall), 64'd0);
        bus.mtlo = 1'b1; bus.wdata = 32'hDEAD;
        #1 chk("busy.stall_mtlo", 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        chk("busy.mtlo_ignored", 64'(bus.lo), 64'hE);
        repeat (4) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush.busy", 64'(bus.busy), 64'd0);
        chk("flush.hi", 64'(bus.hi), 64'h1234);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 1;
        end
        chk("flush.no_done", 64'(seen), 64'd0);
        chk("flush.lo", 64'(bus.lo), 64'hE);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_DIVU; bus.rs_data = 32'd50; bus.rt_data = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.hi", 64'(bus.hi), 64'd0);
        chk("midrst.lo", 64'(bus.lo), 64'd0);
        chk("midrst.busy", 64'(bus.busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 1;
        end
        chk("midrst.no_done", 64'(seen), 64'd0);

        do_op(MDU_MULT, 32'h7FFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFF, 32'h80000001, "mult_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
